// File: rtl/rippleadder.sv
// Registered ripple-carry adder: a chain of WIDTH full-adder cells feeding
// sum/carry/overflow registers, with a one-cycle valid strobe.
module rippleadder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   // c[WIDTH-1] is cin when WIDTH=1, so overflow degenerates to cin ^ cout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum      <= s;
            carry    <= c[WIDTH];
            overflow <= c[WIDTH] ^ c[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_rippleadder.sv
// Self-checking bench for rippleadder (WIDTH=4): directed table, hold,
// mid-stream reset and shuffled exhaustive sweep against an arithmetic model.
module tb_rippleadder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;
   logic         out_valid;

   int n_checks = 0;
   int n_fails  = 0;

   // model of the registered outputs
   logic [W-1:0] m_sum;
   logic         m_carry;
   logic         m_ovf;
   logic         m_valid;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } vec_t;

   vec_t tbl[13];

   rippleadder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Expected outputs from plain integer arithmetic (unsigned and signed views).
   task automatic model_step(input logic r, input logic v, input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input logic ic);
      int total, sa, sb, st;
      if (!r) begin
         m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
      end else begin
         m_valid = v;
         if (v) begin
            total   = int'(ia) + int'(ib) + int'(ic);
            m_sum   = W'(total % (2 ** W));
            m_carry = (total >= 2 ** W);
            sa = ia[W-1] ? int'(ia) - 2 ** W : int'(ia);
            sb = ib[W-1] ? int'(ib) - 2 ** W : int'(ib);
            st = sa + sb + int'(ic);
            m_ovf = (st > 2 ** (W-1) - 1) || (st < -(2 ** (W-1)));
         end
      end
   endtask

   task automatic apply(input string nm, input logic r, input logic v,
                        input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
      rst_n = r; in_valid = v; a = ia; b = ib; cin = ic;
      model_step(r, v, ia, ib, ic);
      @(posedge clk);
      #1;
      chk({nm, ".sum"},       64'(sum),       64'(m_sum));
      chk({nm, ".carry"},     64'(carry),     64'(m_carry));
      chk({nm, ".overflow"},  64'(overflow),  64'(m_ovf));
      chk({nm, ".out_valid"}, 64'(out_valid), 64'(m_valid));
   endtask

   initial begin
      int unsigned perm[512];
      logic [8:0] code;

      tbl[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
      tbl[2]  = '{4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0};
      tbl[3]  = '{4'h0, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[4]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0};
      tbl[5]  = '{4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0};
      tbl[6]  = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[7]  = '{4'h1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0};
      tbl[8]  = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
      tbl[9]  = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
      tbl[10] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
      tbl[11] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
      tbl[12] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};

      // reset with live operands on the inputs
      for (int i = 0; i < 2; i++) begin
         apply("reset", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
         chk("reset.all_zero", 64'({out_valid, overflow, carry, sum}), 64'd0);
      end

      // directed table, back-to-back valid
      for (int i = 0; i < 13; i++) begin
         apply("table", 1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
         chk($sformatf("table[%0d].result", i), 64'({carry, sum}), 64'({tbl[i].c, tbl[i].s}));
         chk($sformatf("table[%0d].overflow", i), 64'(overflow), 64'(tbl[i].o));
         chk($sformatf("table[%0d].out_valid", i), 64'(out_valid), 64'd1);
      end

      // capture then hold while operands toggle
      apply("hold.capture", 1'b1, 1'b1, 4'h3, 4'h4, 1'b0);
      chk("hold.capture_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         apply("hold", 1'b1, 1'b0, (i % 2 == 0) ? 4'hC : 4'h5, (i % 2 == 0) ? 4'hB : 4'hA, 1'b1);
         chk("hold.sum", 64'(sum), 64'h7);
         chk("hold.carry", 64'(carry), 64'd0);
         chk("hold.out_valid", 64'(out_valid), 64'd0);
      end

      // stream of five with reset pulsed at the third
      apply("stream1", 1'b1, 1'b1, 4'h2, 4'h3, 1'b0);
      apply("stream2", 1'b1, 1'b1, 4'h9, 4'h9, 1'b1);
      apply("stream3", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
      chk("stream3.cleared", 64'({out_valid, overflow, carry, sum}), 64'd0);
      apply("stream4", 1'b1, 1'b1, 4'h6, 4'h5, 1'b0);
      chk("stream4.result", 64'({out_valid, overflow, carry, sum}), 64'b1_1_0_1011);
      apply("stream5", 1'b1, 1'b1, 4'hE, 4'h3, 1'b1);
      chk("stream5.result", 64'({out_valid, overflow, carry, sum}), 64'b1_0_1_0010);

      // all 512 operand combinations in shuffled order, random idle cycles
      for (int i = 0; i < 512; i++) perm[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j;
         int unsigned t;
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         if ($urandom_range(3, 0) == 0)
            apply("rand.idle", 1'b1, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
         code = perm[i][8:0];
         apply("rand", 1'b1, 1'b1, code[3:0], code[7:4], code[8]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
